// File: rtl/tpu_pkg.sv
// Shared TPU control-path constants.
// Default widths for the countdown timer block.
package tpu_pkg;

    localparam int DSP_CTR_WIDTH = 6;
    localparam int EVT_CNT_WIDTH = 4;

endpackage

// File: rtl/dsp_down_ctr_if.sv
// Control/status bundle for the loadable down-counter.
// Master drives the controls; slave is the counter.
interface dsp_down_ctr_if
    import tpu_pkg::*;
#(
    parameter int CW = DSP_CTR_WIDTH,
    parameter int EW = EVT_CNT_WIDTH
) ();

    logic          enable;
    logic          load;
    logic [CW-1:0] start_val;
    logic          auto_reload;
    logic [CW-1:0] ctr_val;
    logic          ctr_event;
    logic          busy;
    logic [EW-1:0] evt_cnt;

    modport master (
        output enable, load, start_val, auto_reload,
        input  ctr_val, ctr_event, busy, evt_cnt
    );

    modport slave (
        input  enable, load, start_val, auto_reload,
        output ctr_val, ctr_event, busy, evt_cnt
    );

endinterface

// File: rtl/sat_ctr.sv
// Saturating up-counter with synchronous clear.
// Clear wins over increment; holds at all-ones.
module sat_ctr #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] val
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            val <= '0;
        end else if (clr) begin
            val <= '0;
        end else if (inc && (val != '1)) begin
            val <= val + WIDTH'(1);
        end
    end

endmodule

// File: rtl/dsp_down_ctr.sv
// Loadable down-counter with optional auto-reload,
// zero-reached event pulse and saturating period count.
module dsp_down_ctr
    import tpu_pkg::*;
#(
    parameter int COUNTER_WIDTH   = DSP_CTR_WIDTH,
    parameter int EVENT_CNT_WIDTH = EVT_CNT_WIDTH
) (
    input logic           clk,
    input logic           rst,
    dsp_down_ctr_if.slave bus
);

    localparam logic [COUNTER_WIDTH-1:0] ONE =
        COUNTER_WIDTH'(1);

    logic [COUNTER_WIDTH-1:0] ctr_q;
    logic [COUNTER_WIDTH-1:0] reload_q;
    logic                     busy_q;
    logic                     evt_q;
    logic                     at_one;
    logic                     hit;
    logic                     clr;

    assign at_one = (ctr_q == ONE);
    // Zero is reached only by counting, never by a load.
    assign hit = bus.enable && !bus.load && busy_q && at_one;
    assign clr = bus.enable && bus.load;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctr_q    <= '0;
            reload_q <= '0;
            busy_q   <= 1'b0;
            evt_q    <= 1'b0;
        end else begin
            evt_q <= 1'b0;
            if (bus.enable) begin
                if (bus.load) begin
                    ctr_q    <= bus.start_val;
                    reload_q <= bus.start_val;
                    busy_q   <= (bus.start_val != '0);
                end else if (busy_q) begin
                    if (ctr_q > ONE) begin
                        ctr_q <= ctr_q - ONE;
                    end else if (at_one) begin
                        ctr_q  <= '0;
                        evt_q  <= 1'b1;
                        busy_q <= bus.auto_reload;
                    end else if (bus.auto_reload) begin
                        ctr_q <= reload_q;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
            end
        end
    end

    sat_ctr #(
        .WIDTH (EVENT_CNT_WIDTH)
    ) u_evt_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (hit),
        .val (bus.evt_cnt)
    );

    assign bus.ctr_val   = ctr_q;
    assign bus.ctr_event = evt_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_dsp_down_ctr.sv
// Directed-vector bench for dsp_down_ctr.
// Table of per-edge vectors plus hand-written corner sequences.
module tb_dsp_down_ctr;

    logic clk;
    logic rst;
    int   n_run;
    int   n_fail;

    dsp_down_ctr_if #(.CW(6), .EW(4)) bus ();

    dsp_down_ctr #(
        .COUNTER_WIDTH   (6),
        .EVENT_CNT_WIDTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       ld;
        logic [5:0] sv;
        logic       ar;
        logic [5:0] e_val;
        logic       e_evt;
        logic       e_busy;
        logic [3:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic en, input logic ld,
        input int sv, input logic ar,
        input int ev, input logic ee,
        input logic eb, input int ec
    );
        vec_t v;
        v.en     = en;
        v.ld     = ld;
        v.sv     = 6'(sv);
        v.ar     = ar;
        v.e_val  = 6'(ev);
        v.e_evt  = ee;
        v.e_busy = eb;
        v.e_cnt  = 4'(ec);
        return v;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_all(
        input string nm, input int v, input int e,
        input int b, input int c
    );
        check({nm, ".val"},  int'(bus.ctr_val),   v);
        check({nm, ".evt"},  int'(bus.ctr_event), e);
        check({nm, ".busy"}, int'(bus.busy),      b);
        check({nm, ".cnt"},  int'(bus.evt_cnt),   c);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(
        input logic en, input logic ld,
        input int sv, input logic ar
    );
        bus.enable      = en;
        bus.load        = ld;
        bus.start_val   = 6'(sv);
        bus.auto_reload = ar;
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        rst    = 1'b0;
        drive(0, 0, 0, 0);

        // Test 1: load ignored while disabled
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 1, 9, 0, 0, 0, 0, 0));
        // Test 2: one-shot from 5
        tbl.push_back(mk(1, 1, 5, 0, 5, 0, 1, 0));
        for (int k = 4; k >= 1; k--)
            tbl.push_back(mk(1, 0, 0, 0, k, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1));
        // Test 4: reload on the edge where ctr_val==1
        tbl.push_back(mk(1, 1, 4, 0, 4, 0, 1, 0));
        for (int k = 3; k >= 1; k--)
            tbl.push_back(mk(1, 0, 0, 0, k, 0, 1, 0));
        tbl.push_back(mk(1, 1, 7, 0, 7, 0, 1, 0));
        // Test 5: pause at 3 with enable low
        tbl.push_back(mk(1, 1, 6, 0, 6, 0, 1, 0));
        for (int k = 5; k >= 3; k--)
            tbl.push_back(mk(1, 0, 0, 0, k, 0, 1, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 0, 0, 0, 3, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 2, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1));

        step();
        step();
        check_all("reset", 0, 0, 0, 0);
        rst = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].ld, tbl[i].sv, tbl[i].ar);
            step();
            check_all($sformatf("vec%0d", i),
                tbl[i].e_val, tbl[i].e_evt,
                tbl[i].e_busy, tbl[i].e_cnt);
        end

        // Test 3: auto-reload period 4, evt_cnt saturates
        drive(1, 1, 3, 1);
        step();
        check_all("ar.load", 3, 0, 1, 0);
        drive(1, 0, 0, 1);
        for (int p = 0; p < 20; p++) begin
            for (int k = 2; k >= 0; k--) begin
                step();
                check($sformatf("ar.p%0d.val", p),
                    int'(bus.ctr_val), k);
                check($sformatf("ar.p%0d.evt", p),
                    int'(bus.ctr_event), (k == 0) ? 1 : 0);
            end
            check($sformatf("ar.p%0d.cnt", p),
                int'(bus.evt_cnt), (p + 1 > 15) ? 15 : p + 1);
            step();
            check($sformatf("ar.p%0d.rl", p),
                int'(bus.ctr_val), 3);
        end
        check_all("ar.sat", 3, 0, 1, 15);

        // Drop auto_reload mid-run: finishes this period, then idles
        drive(1, 0, 0, 0);
        step();
        step();
        step();
        check_all("ar.drop", 0, 1, 0, 15);
        step();
        check_all("ar.idle", 0, 0, 0, 15);

        // Test 6: async reset mid-count
        drive(1, 1, 10, 0);
        step();
        drive(1, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            step();
        check_all("pre_rst", 5, 0, 1, 0);
        #2;
        rst = 1'b0;
        #1;
        check_all("async_rst", 0, 0, 0, 0);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_all($sformatf("post_rst%0d", i), 0, 0, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
